// File: rtl/ysyx_23060111_pkg.sv
// Shared definitions for the ysyx_23060111 core: IFU state encoding and
// architectural constants used by fetch.
package ysyx_23060111_pkg;

    typedef enum logic [2:0] {
        IFU_IDLE    = 3'd0,
        IFU_REQ     = 3'd1,
        IFU_RESP    = 3'd2,
        IFU_HOLD    = 3'd3,
        IFU_WAIT_PC = 3'd4
    } ifu_state_t;

    // addi x0, x0, 0 -- substituted for any word that faulted
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060111_ifu.sv
// Instruction fetch unit: one word fetch per instruction, handed to decode,
// then waits for write-back's next PC. YSYX_23060111_IFU_ALIGN_CHECK_EN
// enables a local misaligned-PC fault instead of issuing the request.
module ysyx_23060111_ifu
    import ysyx_23060111_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,

    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        mem_resp_err,

    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,

    input  logic        npc_valid,
    input  logic [31:0] npc,
    output logic        npc_ready
);

    ifu_state_t  state;
    logic [31:0] pc;
    logic        misaligned;

`ifdef YSYX_23060111_IFU_ALIGN_CHECK_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Handshake strobes are pure state decode so they never glitch on inputs
    assign mem_req_valid = (state == IFU_REQ) && !misaligned;
    assign mem_req_addr  = pc;
    assign inst_valid    = (state == IFU_HOLD);
    assign npc_ready     = (state == IFU_WAIT_PC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IFU_IDLE;
            pc         <= RESET_PC;
            inst       <= '0;
            inst_pc    <= '0;
            inst_fault <= 1'b0;
        end else begin
            case (state)
                IFU_IDLE: begin
                    state <= IFU_REQ;
                end
                IFU_REQ: begin
                    if (misaligned) begin
                        inst       <= NOP_INST;
                        inst_pc    <= pc;
                        inst_fault <= 1'b1;
                        state      <= IFU_HOLD;
                    end else if (mem_req_ready) begin
                        state <= IFU_RESP;
                    end
                end
                IFU_RESP: begin
                    if (mem_resp_valid) begin
                        inst       <= mem_resp_err ? NOP_INST : mem_resp_data;
                        inst_pc    <= pc;
                        inst_fault <= mem_resp_err;
                        state      <= IFU_HOLD;
                    end
                end
                IFU_HOLD: begin
                    if (inst_ready) begin
                        state <= IFU_WAIT_PC;
                    end
                end
                IFU_WAIT_PC: begin
                    if (npc_valid) begin
                        pc    <= npc;
                        state <= IFU_REQ;
                    end
                end
                default: begin
                    state <= IFU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060111_ifu.sv
// Self-checking bench for ysyx_23060111_ifu: a behavioural memory/decode/
// write-back environment with a PC model, randomized waits and data.
module tb_ysyx_23060111_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        npc_valid;
    logic [31:0] npc;
    logic        npc_ready;

    ysyx_23060111_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_err   (mem_resp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .npc_valid      (npc_valid),
        .npc            (npc),
        .npc_ready      (npc_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // architectural PC the IFU should be fetching from next
    logic [31:0] exp_pc;

    // observations recorded by run_fetch
    bit          got_req;
    int          t_req, t_next, unstable, dups;
    logic [31:0] obs_addr, obs_inst, obs_pc, obs_next_addr;
    logic        obs_fault, obs_inst_valid, obs_npc_ready, obs_next_valid;

    task automatic wait_req();
        got_req = 1'b0;
        for (int i = 0; i < 20 && !got_req; i++) begin
            if (mem_req_valid) got_req = 1'b1;
            else @(negedge clk);
        end
        t_req    = cyc;
        obs_addr = mem_req_addr;
    endtask

    // One full fetch loop as seen by memory, decode and write-back.
    task automatic run_fetch(input int req_wait, input int resp_wait, input int hold_wait,
                             input logic [31:0] data, input logic err,
                             input logic [31:0] next_pc, input bit early_npc);
        unstable = 0;
        dups     = 0;
        wait_req();
        if (!got_req) return;
        for (int i = 0; i < req_wait; i++) begin
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'($urandom_range(0, 1));
            mem_resp_data  = $urandom;
            @(negedge clk);
            if (!mem_req_valid || mem_req_addr !== obs_addr) unstable++;
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        if (mem_req_valid) dups++;
        for (int i = 0; i < resp_wait; i++) begin
            @(negedge clk);
            if (mem_req_valid || inst_valid) dups++;
        end
        mem_resp_valid = 1'b1;
        mem_resp_data  = data;
        mem_resp_err   = err;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;
        obs_inst_valid = inst_valid;
        obs_inst       = inst;
        obs_pc         = inst_pc;
        obs_fault      = inst_fault;
        if (early_npc) begin
            npc_valid = 1'b1;
            npc       = next_pc;
        end
        for (int i = 0; i < hold_wait; i++) begin
            inst_ready     = 1'b0;
            mem_resp_valid = 1'($urandom_range(0, 1));
            mem_resp_data  = $urandom;
            mem_resp_err   = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!inst_valid || inst !== obs_inst || inst_pc !== obs_pc ||
                inst_fault !== obs_fault || npc_ready || mem_req_valid) unstable++;
        end
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;
        inst_ready     = 1'b1;
        @(negedge clk);
        inst_ready    = 1'b0;
        obs_npc_ready = npc_ready;
        npc_valid     = 1'b1;
        npc           = next_pc;
        @(negedge clk);
        npc_valid      = 1'b0;
        npc            = $urandom;
        t_next         = cyc;
        obs_next_valid = mem_req_valid;
        obs_next_addr  = mem_req_addr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0 || npc_ready !== 1'b0 ||
                inst !== 32'h0 || inst_pc !== 32'h0 || inst_fault !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs: req_v=%b inst_v=%b npc_r=%b inst=%h pc=%h flt=%b, all must be 0",
                         mem_req_valid, inst_valid, npc_ready, inst, inst_pc, inst_fault);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC) begin
            failures++;
            $display("FAIL reset_first_req: valid=%b addr=%h, expected 1 / %h",
                     mem_req_valid, mem_req_addr, RST_PC);
        end
        exp_pc = RST_PC;
    endtask

    task automatic test_zero_wait();
        run_fetch(0, 0, 0, 32'h0010_0073, 1'b0, 32'h8000_0004, 1'b0);
        checks++;
        if (!got_req || obs_addr !== exp_pc) begin
            failures++;
            $display("FAIL zw_req: got=%0d addr=%h, expected %h", got_req, obs_addr, exp_pc);
        end
        checks++;
        if (obs_inst_valid !== 1'b1 || obs_inst !== 32'h0010_0073 || obs_pc !== exp_pc || obs_fault !== 1'b0) begin
            failures++;
            $display("FAIL zw_inst: v=%b inst=%h pc=%h flt=%b, expected 1/00100073/%h/0",
                     obs_inst_valid, obs_inst, obs_pc, obs_fault, exp_pc);
        end
        checks++;
        if (obs_npc_ready !== 1'b1) begin
            failures++;
            $display("FAIL zw_npc_ready: got %b, expected 1", obs_npc_ready);
        end
        checks++;
        if (obs_next_valid !== 1'b1 || obs_next_addr !== 32'h8000_0004 || (t_next - t_req) != 4) begin
            failures++;
            $display("FAIL zw_loop: v=%b addr=%h cycles=%0d, expected 1/80000004/4",
                     obs_next_valid, obs_next_addr, t_next - t_req);
        end
        exp_pc = 32'h8000_0004;
    endtask

    task automatic test_back_pressure();
        run_fetch(3, 2, 5, 32'h0041_0113, 1'b0, 32'h8000_0008, 1'b0);
        checks++;
        if (!got_req || obs_addr !== exp_pc) begin
            failures++;
            $display("FAIL bp_req: got=%0d addr=%h, expected %h", got_req, obs_addr, exp_pc);
        end
        checks++;
        if (unstable != 0 || dups != 0) begin
            failures++;
            $display("FAIL bp_stable: unstable=%0d dups=%0d, expected 0/0", unstable, dups);
        end
        checks++;
        if (obs_inst !== 32'h0041_0113 || obs_pc !== exp_pc || obs_fault !== 1'b0) begin
            failures++;
            $display("FAIL bp_inst: inst=%h pc=%h flt=%b, expected 00410113/%h/0", obs_inst, obs_pc, obs_fault, exp_pc);
        end
        checks++;
        if (obs_next_valid !== 1'b1 || obs_next_addr !== 32'h8000_0008) begin
            failures++;
            $display("FAIL bp_next: v=%b addr=%h, expected 1/80000008", obs_next_valid, obs_next_addr);
        end
        exp_pc = 32'h8000_0008;
    endtask

    task automatic test_fault();
        run_fetch(1, 1, 1, 32'hDEAD_BEEF, 1'b1, 32'h8000_000C, 1'b0);
        checks++;
        if (obs_inst_valid !== 1'b1 || obs_inst !== NOP || obs_fault !== 1'b1 || obs_pc !== exp_pc) begin
            failures++;
            $display("FAIL fault_inst: v=%b inst=%h flt=%b pc=%h, expected 1/%h/1/%h",
                     obs_inst_valid, obs_inst, obs_fault, obs_pc, NOP, exp_pc);
        end
        exp_pc = 32'h8000_000C;
    endtask

    task automatic test_redirect();
        run_fetch(0, 0, 3, 32'h0000_0517, 1'b0, 32'h8000_0100, 1'b1);
        checks++;
        if (unstable != 0 || obs_npc_ready !== 1'b1) begin
            failures++;
            $display("FAIL redirect_early: unstable=%0d npc_ready=%b, expected 0/1", unstable, obs_npc_ready);
        end
        checks++;
        if (obs_next_valid !== 1'b1 || obs_next_addr !== 32'h8000_0100) begin
            failures++;
            $display("FAIL redirect_addr: v=%b addr=%h, expected 1/80000100", obs_next_valid, obs_next_addr);
        end
        exp_pc = 32'h8000_0100;
    endtask

    task automatic test_random();
        logic [31:0] data, nxt, exp_inst;
        logic        err;
        for (int n = 0; n < 16; n++) begin
            data = $urandom;
            err  = ($urandom_range(0, 7) == 0);
            nxt  = $urandom;
            nxt[1:0] = 2'b00;
            exp_inst = err ? NOP : data;
            run_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      data, err, nxt, 1'($urandom_range(0, 1)));
            checks++;
            if (!got_req || obs_addr !== exp_pc || unstable != 0 || dups != 0) begin
                failures++;
                $display("FAIL rand_req[%0d]: got=%0d addr=%h unstable=%0d dups=%0d, expected %h/0/0",
                         n, got_req, obs_addr, unstable, dups, exp_pc);
            end
            checks++;
            if (obs_inst !== exp_inst || obs_pc !== exp_pc || obs_fault !== err) begin
                failures++;
                $display("FAIL rand_inst[%0d]: inst=%h pc=%h flt=%b, expected %h/%h/%b",
                         n, obs_inst, obs_pc, obs_fault, exp_inst, exp_pc, err);
            end
            exp_pc = nxt;
        end
    endtask

    task automatic test_midop_reset();
        wait_req();
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0 || npc_ready !== 1'b0 ||
            inst !== 32'h0 || inst_pc !== 32'h0 || inst_fault !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs: req_v=%b inst_v=%b npc_r=%b inst=%h pc=%h flt=%b, all must be 0",
                     mem_req_valid, inst_valid, npc_ready, inst, inst_pc, inst_fault);
        end
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC) begin
            failures++;
            $display("FAIL midrst_refetch: v=%b addr=%h, expected 1/%h", mem_req_valid, mem_req_addr, RST_PC);
        end
        exp_pc = RST_PC;
        run_fetch(0, 1, 0, 32'h0000_0093, 1'b0, 32'h8000_0010, 1'b0);
        checks++;
        if (obs_inst !== 32'h0000_0093 || obs_pc !== RST_PC) begin
            failures++;
            $display("FAIL midrst_inst: inst=%h pc=%h, expected 00000093/%h", obs_inst, obs_pc, RST_PC);
        end
        exp_pc = 32'h8000_0010;
    endtask

    task automatic test_align();
        run_fetch(0, 0, 0, 32'h0000_0013, 1'b0, 32'h8000_0002, 1'b0);
`ifdef YSYX_23060111_IFU_ALIGN_CHECK_EN
        checks++;
        if (obs_next_valid !== 1'b0) begin
            failures++;
            $display("FAIL align_no_req: req_valid=%b, expected 0", obs_next_valid);
        end
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || inst !== NOP || inst_pc !== 32'h8000_0002 || inst_fault !== 1'b1) begin
            failures++;
            $display("FAIL align_fault: v=%b inst=%h pc=%h flt=%b, expected 1/%h/80000002/1",
                     inst_valid, inst, inst_pc, inst_fault, NOP);
        end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        npc_valid  = 1'b1;
        npc        = 32'h8000_0200;
        @(negedge clk);
        npc_valid = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0200) begin
            failures++;
            $display("FAIL align_recover: v=%b addr=%h, expected 1/80000200", mem_req_valid, mem_req_addr);
        end
`else
        checks++;
        if (obs_next_valid !== 1'b1 || obs_next_addr !== 32'h8000_0002) begin
            failures++;
            $display("FAIL align_passthru: v=%b addr=%h, expected 1/80000002", obs_next_valid, obs_next_addr);
        end
        run_fetch(0, 0, 0, 32'h1234_5678, 1'b0, 32'h8000_0200, 1'b0);
        checks++;
        if (obs_inst !== 32'h1234_5678 || obs_pc !== 32'h8000_0002 || obs_fault !== 1'b0) begin
            failures++;
            $display("FAIL align_inst: inst=%h pc=%h flt=%b, expected 12345678/80000002/0",
                     obs_inst, obs_pc, obs_fault);
        end
`endif
        exp_pc = 32'h8000_0200;
    endtask

    initial begin
        rst            = 1'b1;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        mem_resp_err   = 1'b0;
        inst_ready     = 1'b0;
        npc_valid      = 1'b0;
        npc            = 32'h0;
        exp_pc         = RST_PC;
        test_reset();
        test_zero_wait();
        test_back_pressure();
        test_fault();
        test_redirect();
        test_random();
        test_midop_reset();
        test_align();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ysyx_23060111_ifu.md
# ysyx_23060111_ifu

Instruction fetch unit for the multi-cycle ysyx_23060111 core. Holds the architectural PC, issues one word-fetch request per instruction on a valid/ready memory port, registers the returned word, and presents it with its PC to the instruction decode stage on a valid/ready handshake. It then waits for the next PC from write-back before fetching again. It is the producer end of the `inst` interface the decode stage consumes.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC loaded on reset.
- `clk` in 1: core clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_req_valid` out 1: fetch request valid.
- `mem_req_ready` in 1: memory accepts request.
- `mem_req_addr` out 32: fetch address (current PC).
- `mem_resp_valid` in 1: fetch data valid. The IFU never back-pressures responses.
- `mem_resp_data` in 32: fetched instruction word.
- `mem_resp_err` in 1: access fault for this response.
- `inst_valid` out 1: `inst`/`inst_pc` valid for decode.
- `inst_ready` in 1: decode accepts the instruction.
- `inst` out 32: instruction word.
- `inst_pc` out 32: PC of `inst`.
- `inst_fault` out 1: fetch faulted. `inst` is 32'h0000_0013 (nop) when set.
- `npc_valid` in 1: write-back presents the next PC.
- `npc` in 32: next PC (dnpc) from write-back.
- `npc_ready` out 1: IFU accepts `npc`.

## Operation
- State machine has five states: IDLE, REQ, RESP, HOLD, WAIT_PC.
- **IDLE:** reset state. Moves unconditionally to REQ on the next cycle.
- **REQ:**
  - `mem_req_valid`=1 and `mem_req_addr`=pc.
  - On `mem_req_valid & mem_req_ready`, go to RESP.
- **RESP:**
  - On `mem_resp_valid`, register `inst`=`mem_resp_data` (nop if `mem_resp_err`), `inst_pc`=pc and `inst_fault`=`mem_resp_err`.
  - Go to HOLD.
- **HOLD:**
  - `inst_valid`=1. `inst`, `inst_pc` and `inst_fault` hold stable until the handshake.
  - On `inst_valid & inst_ready`, go to WAIT_PC.
- **WAIT_PC:**
  - `npc_ready`=1.
  - On `npc_valid`, set pc=`npc` and go to REQ.
- `npc_valid` outside WAIT_PC is ignored. Write-back must hold it until `npc_ready`.
- `mem_resp_valid` outside RESP is ignored.
- All arithmetic is 32-bit. The IFU does no PC increment; write-back always supplies `npc`.
- Reset values: state=IDLE, pc=`RESET_PC`, `inst`=0, `inst_pc`=0, `inst_fault`=0. All valid/ready outputs are 0.
- Reset mid-operation returns to IDLE and discards any in-flight fetch. Memory shares `rst`, so no stale response arrives after reset.

## Timing
- All handshake outputs decode combinationally from the state register. Data outputs are registered.
- `mem_req_valid` first rises on the second cycle after `rst` is sampled low: IDLE takes one cycle, then REQ.
- Response accepted in cycle n gives `inst_valid`=1 in cycle n+1.
- `inst` handshake in cycle n gives `npc_ready`=1 in cycle n+1.
- `npc` accepted in cycle m gives `mem_req_valid`=1 with the new address in cycle m+1.
- Minimum fetch loop with zero-wait memory and stages is 4 cycles: REQ, RESP, HOLD, WAIT_PC.
- `mem_req_addr` is stable while `mem_req_valid` is high and unaccepted.

## Configuration
- Macro: `YSYX_23060111_IFU_ALIGN_CHECK_EN`.
- **Defined:**
  - In REQ with pc[1:0]≠0, no memory request is issued (`mem_req_valid`=0).
  - Next cycle goes to HOLD with `inst`=nop, `inst_pc`=pc and `inst_fault`=1.
- **Undefined:** pc[1:0] is not checked. The address goes out unchanged and the memory defines the result.

## Structure
- Shared package `ysyx_23060111_pkg` holds:
  - the state enum `ifu_state_t`;
  - `NOP_INST` = 32'h0000_0013;
  - `RESET_PC_DEFAULT`.
- No sub-module is needed. A single always block holds the state/pc/output registers, plus combinational handshake decode.

## Test plan
- **Reset:** hold `rst` 3 cycles, then release.
  - → `mem_req_valid` rises 2 cycles after release with `mem_req_addr`=32'h8000_0000.
  - → all outputs are 0 during reset.
- **Zero-wait loop:** response data 32'h0010_0073 (ebreak), `inst_ready`=1, `npc`=32'h8000_0004.
  - → `inst`=32'h0010_0073, `inst_pc`=32'h8000_0000.
  - → next request has addr 32'h8000_0004, 4 cycles after the first.
- **Back-pressure:** `mem_req_ready` low 3 cycles, response delayed 2 cycles, `inst_ready` low 5 cycles.
  - → addr held stable throughout.
  - → `inst` held stable throughout.
  - → no duplicate request.
- **Fault:** `mem_resp_err`=1 with data 32'hDEAD_BEEF.
  - → `inst_fault`=1, `inst`=32'h0000_0013.
- **Redirect:** `npc`=32'h8000_0100 pulsed early (during HOLD) and held.
  - → ignored until WAIT_PC.
  - → next `mem_req_addr`=32'h8000_0100.
- **Mid-op reset / alignment:**
  - `rst` asserted in RESP → IDLE, then fetch from 32'h8000_0000.
  - With the macro defined, `npc`=32'h8000_0002 → no request, `inst_fault`=1, `inst_pc`=32'h8000_0002.
